// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the double-buffered framebuffer arbiter.
// Optional copy-back feature is selected by FB_ARB_COPY_EN.
package fb_arb_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      COPY
   } state_t;

   typedef logic page_t;

endpackage

// File: rtl/fb_copy_engine.sv
// Copies the front page into the back page after a flip, one pixel per
// read/write pair, yielding to the scanner on every display read cycle.
module fb_copy_engine
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              active,
   input  logic              disp_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              req,
   output logic              we,
   output page_t             to_back,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              done
);

   logic              phase;
   logic              fresh;
   logic [ADDR_W-1:0] cnt;
   logic [DATA_W-1:0] capt;
   logic              rd_go;
   logic              wr_go;

   assign rd_go   = active & ~phase & ~disp_re;
   assign wr_go   = active & phase & ~disp_re;
   assign req     = rd_go | wr_go;
   assign we      = wr_go;
   assign to_back = phase;
   assign addr    = cnt;
   assign wdata   = fresh ? mem_rdata : capt;
   assign done    = wr_go & (cnt == '1);

   // Advance phase/counter and hold read data until the write slot is free
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase <= 1'b0;
         fresh <= 1'b0;
         cnt   <= '0;
         capt  <= '0;
      end else begin
         fresh <= rd_go;
         if (fresh)
            capt <= mem_rdata;
         if (!active) begin
            phase <= 1'b0;
            cnt   <= '0;
         end else if (rd_go) begin
            phase <= 1'b1;
         end else if (wr_go) begin
            phase <= 1'b0;
            cnt   <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares one 2-page RAM between scanner reads and host writes; flips
// pages on frame boundaries. FB_ARB_COPY_EN adds front-to-back copy.
module framebuffer_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_disp_re,
   input  logic [ADDR_W-1:0] i_disp_raddr,
   output logic [DATA_W-1:0] o_disp_rdata,
   input  logic              i_disp_frame_done,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_swap_req,
   output logic              o_swap_pending,
   output logic              o_swap_done,
   output logic              o_front_page,
   output logic [ADDR_W:0]   o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   state_t            state;
   state_t            state_nx;
   page_t             front;
   logic              wr_acc;
   logic              flip;
   logic              cp_req;
   logic              cp_we;
   page_t             cp_back;
   logic [ADDR_W-1:0] cp_addr;
   logic [DATA_W-1:0] cp_wdata;
   logic              cp_done;

   assign o_wr_ready     = (state == IDLE) & ~i_disp_re;
   assign wr_acc         = i_wr_valid & o_wr_ready;
   assign o_swap_pending = (state != IDLE);
   assign o_front_page   = front;
   assign o_disp_rdata   = i_mem_rdata;
   assign flip           = (state == PENDING) & i_disp_frame_done;

`ifdef FB_ARB_COPY_EN
   fb_copy_engine #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_copy (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .active    (state == COPY),
      .disp_re   (i_disp_re),
      .mem_rdata (i_mem_rdata),
      .req       (cp_req),
      .we        (cp_we),
      .to_back   (cp_back),
      .addr      (cp_addr),
      .wdata     (cp_wdata),
      .done      (cp_done)
   );
`else
   assign cp_req   = 1'b0;
   assign cp_we    = 1'b0;
   assign cp_back  = 1'b0;
   assign cp_addr  = '0;
   assign cp_wdata = '0;
   assign cp_done  = 1'b0;
`endif

   // RAM port mux: scanner first, then host write, then copy engine
   always_comb begin
      o_mem_addr  = {front, i_disp_raddr};
      o_mem_we    = 1'b0;
      o_mem_wdata = i_wr_data;
      if (i_disp_re) begin
         o_mem_we = 1'b0;
      end else if (wr_acc) begin
         o_mem_addr = {~front, i_wr_addr};
         o_mem_we   = 1'b1;
      end else if (cp_req) begin
         o_mem_addr  = {front ^ cp_back, cp_addr};
         o_mem_we    = cp_we;
         o_mem_wdata = cp_wdata;
      end
   end

   // Next-state: a request waits for the next frame boundary to commit
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (i_swap_req) state_nx = PENDING;
         PENDING: begin
            if (i_disp_frame_done) begin
`ifdef FB_ARB_COPY_EN
               state_nx = COPY;
`else
               state_nx = IDLE;
`endif
            end
         end
         COPY:    if (cp_done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State, front page and flip pulse registers
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         front       <= 1'b0;
         o_swap_done <= 1'b0;
      end else begin
         state       <= state_nx;
         o_swap_done <= flip;
         if (flip)
            front <= ~front;
      end
   end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a RAM model and a
// scoreboard of expected scanner read data.
module tb_framebuffer_arbiter;

   localparam int AW = 8;
   localparam int DW = 16;

`ifdef FB_ARB_COPY_EN
   localparam bit COPY_ON = 1'b1;
`else
   localparam bit COPY_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          disp_re = 1'b0;
   logic [AW-1:0] disp_raddr = '0;
   logic [DW-1:0] disp_rdata;
   logic          frame_done = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          swap_req = 1'b0;
   logic          swap_pending;
   logic          swap_done;
   logic          front_page;
   logic [AW:0]   mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   logic [DW-1:0] ram     [0:(1<<(AW+1))-1];
   logic [DW-1:0] exp_mem [0:(1<<(AW+1))-1];
   logic [DW-1:0] sbq [$];
   logic          rd_q = 1'b0;
   logic          exp_front = 1'b0;
   int            checks = 0;
   int            failures = 0;

   framebuffer_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_disp_re         (disp_re),
      .i_disp_raddr      (disp_raddr),
      .o_disp_rdata      (disp_rdata),
      .i_disp_frame_done (frame_done),
      .i_wr_valid        (wr_valid),
      .o_wr_ready        (wr_ready),
      .i_wr_addr         (wr_addr),
      .i_wr_data         (wr_data),
      .i_swap_req        (swap_req),
      .o_swap_pending    (swap_pending),
      .o_swap_done       (swap_done),
      .o_front_page      (front_page),
      .o_mem_addr        (mem_addr),
      .o_mem_we          (mem_we),
      .o_mem_wdata       (mem_wdata),
      .i_mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port RAM with one cycle read latency
   always @(posedge clk) begin
      if (mem_we)
         ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] req_v);
      checks++;
      assert (obs === req_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, req_v);
      end
   endtask

   // Scoreboard: a read issued at one edge is compared in the next cycle
   always @(posedge clk) rd_q <= disp_re & rst_n;

   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (rd_q) begin
         e = (sbq.size() != 0) ? sbq.pop_front() : 'x;
         chk("disp_rdata", 32'(disp_rdata), 32'(e));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      disp_re    = 1'b1;
      disp_raddr = a;
      sbq.push_back(exp_mem[{exp_front, a}]);
      tick();
      disp_re = 1'b0;
   endtask

   // Scanner reads every other cycle until the host port reopens
   task automatic copy_wait(input string tag);
      int nwr = 0;
      int bad = 0;
      bit ok = 1'b0;
      logic [AW:0] b;
      for (int c = 0; c < 2000; c++) begin
         disp_re    = c[0];
         disp_raddr = AW'(c * 7);
         if (disp_re)
            sbq.push_back(exp_mem[{exp_front, disp_raddr}]);
         @(negedge clk);
         if (mem_we) nwr++;
         if (!disp_re && wr_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      disp_re = 1'b0;
      tick();
      chk({tag, "_done"}, 32'(ok), 32'd1);
      chk({tag, "_nwr"}, 32'(nwr), 32'd256);
      for (int i = 0; i < 256; i++) begin
         b = {~exp_front, AW'(i)};
         if (ram[b] !== exp_mem[{exp_front, AW'(i)}]) bad++;
         exp_mem[b] = exp_mem[{exp_front, AW'(i)}];
      end
      chk({tag, "_pages"}, 32'(bad), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         ram[i]     = DW'(16'h1000 + i * 3);
         exp_mem[i] = DW'(16'h1000 + i * 3);
      end

      // Reset state
      tick();
      tick();
      chk("rst_front", 32'(front_page), 0);
      chk("rst_pending", 32'(swap_pending), 0);
      chk("rst_done", 32'(swap_done), 0);
      chk("rst_we", 32'(mem_we), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_ready", 32'(wr_ready), 1);

      // Scanner wins a conflict; host write lands next cycle on page 1
      disp_re    = 1'b1;
      disp_raddr = 8'h12;
      wr_valid   = 1'b1;
      wr_addr    = 8'h12;
      wr_data    = 16'hBEEF;
      sbq.push_back(exp_mem[{1'b0, 8'h12}]);
      @(negedge clk);
      chk("conf_ready", 32'(wr_ready), 0);
      chk("conf_we", 32'(mem_we), 0);
      chk("conf_addr", 32'(mem_addr), 32'h012);
      tick();
      disp_re = 1'b0;
      @(negedge clk);
      chk("wr_ready", 32'(wr_ready), 1);
      chk("wr_we", 32'(mem_we), 1);
      chk("wr_addr", 32'(mem_addr), 32'h112);
      tick();
      wr_valid = 1'b0;
      exp_mem[9'h112] = 16'hBEEF;
      chk("ram_112", 32'(ram[9'h112]), 32'hBEEF);
      rd(8'h12);

      // Swap request with a same-cycle write included in the flip
      swap_req = 1'b1;
      wr_valid = 1'b1;
      wr_addr  = 8'h34;
      wr_data  = 16'hCAFE;
      @(negedge clk);
      chk("swapwr_we", 32'(mem_we), 1);
      tick();
      swap_req = 1'b0;
      exp_mem[9'h134] = 16'hCAFE;
      chk("ram_134", 32'(ram[9'h134]), 32'hCAFE);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         chk("pend", 32'(swap_pending), 1);
         chk("pend_we", 32'(mem_we), 0);
         tick();
      end
      wr_valid   = 1'b0;
      frame_done = 1'b1;
      @(negedge clk);
      chk("pre_done", 32'(swap_done), 0);
      chk("pre_front", 32'(front_page), 0);
      tick();
      frame_done = 1'b0;
      exp_front  = 1'b1;
      chk("flip_done", 32'(swap_done), 1);
      chk("flip_front", 32'(front_page), 1);
      chk("flip_pend", 32'(swap_pending), 32'(COPY_ON));
      tick();
      chk("done_pulse", 32'(swap_done), 0);
      if (COPY_ON)
         copy_wait("copy1");
      rd(8'h12);
      rd(8'h34);
      rd(8'hFF);

      // Frame boundary while idle does nothing
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      chk("idle_fd_front", 32'(front_page), 1);
      chk("idle_fd_done", 32'(swap_done), 0);
      chk("idle_fd_pend", 32'(swap_pending), 0);

      // Request coinciding with frame_done waits for the next boundary
      swap_req   = 1'b1;
      frame_done = 1'b1;
      tick();
      swap_req   = 1'b0;
      frame_done = 1'b0;
      chk("sim_front", 32'(front_page), 1);
      chk("sim_pend", 32'(swap_pending), 1);
      chk("sim_done", 32'(swap_done), 0);
      tick();
      tick();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      exp_front  = 1'b0;
      chk("sim2_front", 32'(front_page), 0);
      chk("sim2_done", 32'(swap_done), 1);
      if (COPY_ON)
         copy_wait("copy2");
      rd(8'h12);
      rd(8'h34);

      // Reset in the middle of a copy (or a pending flip)
      swap_req = 1'b1;
      tick();
      swap_req   = 1'b0;
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      chk("rflip_front", 32'(front_page), 1);
      if (COPY_ON) begin
         int nwr = 0;
         for (int c = 0; c < 1000 && nwr < 100; c++) begin
            @(negedge clk);
            if (mem_we) nwr++;
            tick();
         end
         chk("rcopy_cnt", 32'(nwr), 32'd100);
         chk("rcopy_busy", 32'(swap_pending), 1);
      end else begin
         swap_req = 1'b1;
         tick();
         swap_req = 1'b0;
         chk("rpend_busy", 32'(swap_pending), 1);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rmid_front", 32'(front_page), 0);
      chk("rmid_pend", 32'(swap_pending), 0);
      chk("rmid_we", 32'(mem_we), 0);
      tick();
      chk("rmid_ready", 32'(wr_ready), 1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
